sprite_blitter: RTL and testbench

//  Writer side of the vga_adapter plot interface (x, y, colour, plot).
//  On a start pulse it copies one SPRITE_W x SPRITE_H sprite from a sync-read

---
 rtl/sprite_blitter.sv | 130 +++++++++++++
 tb/tb_sprite_blitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPRITE_W x SPRITE_H sprite from a sync-read ROM to the
// vga_adapter plot port, one pixel per cycle. Optional colour-key via SPRITE_TRANSPARENCY_EN.
module sprite_blitter #(
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter logic [7:0]  TRANSPARENT = 8'hE3
) (
  input  logic                                               clk,
  input  logic                                               resetn,
  input  logic                                               start,
  input  logic [ID_W-1:0]                                    spriteId,
  input  logic [7:0]                                         originX,
  input  logic [6:0]                                         originY,
  output logic [ID_W+$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0]  romAddr,
  input  logic [7:0]                                         romData,
  output logic [7:0]                                         x,
  output logic [6:0]                                         y,
  output logic [7:0]                                         colour,
  output logic                                               writeEn,
  output logic                                               busy,
  output logic                                               done
);

  localparam int unsigned COL_W = $clog2(SPRITE_W);
  localparam int unsigned ROW_W = $clog2(SPRITE_H);
  localparam int unsigned IDX_W = COL_W + ROW_W;
  localparam int unsigned N     = SPRITE_W * SPRITE_H;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [ID_W-1:0]  r_id;
  logic [7:0]       r_ox;
  logic [6:0]       r_oy;
  // Coordinate pipeline: stage 0 aligned with romAddr, stage 1 aligned with romData
  logic             r_v0, r_v1;
  logic [8:0]       r_sx0, r_sx1;
  logic [7:0]       r_sy0, r_sy1;

  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_in_bounds;
  logic             w_key_hit;
  logic             w_opaque;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  assign w_idx_nxt   = r_idx + IDX_W'(1);
  assign w_in_bounds = (r_sx1 < 9'(SCREEN_W)) && (r_sy1 < 8'(SCREEN_H));
  assign w_key_hit   = (romData == TRANSPARENT);
  assign w_opaque    = !(KEY_EN && w_key_hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_id    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_sx0   <= '0;
      r_sx1   <= '0;
      r_sy0   <= '0;
      r_sy1   <= '0;
      romAddr <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_v1    <= r_v0;
      r_sx1   <= r_sx0;
      r_sy1   <= r_sy0;
      x       <= r_sx1[7:0];
      y       <= r_sy1[6:0];
      colour  <= romData;
      writeEn <= r_v1 && w_in_bounds && w_opaque;
      done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            busy    <= 1'b1;
            r_id    <= spriteId;
            r_ox    <= originX;
            r_oy    <= originY;
            r_idx   <= '0;
            romAddr <= {spriteId, IDX_W'(0)};
            r_v0    <= 1'b1;
            r_sx0   <= 9'(originX);
            r_sy0   <= 8'(originY);
          end
        end
        S_RUN: begin
          if (r_idx == IDX_W'(N - 1)) begin
            r_state <= S_DRAIN1;
            r_v0    <= 1'b0;
          end else begin
            r_idx   <= w_idx_nxt;
            romAddr <= {r_id, w_idx_nxt};
            r_sx0   <= 9'(r_ox) + 9'(w_idx_nxt[COL_W-1:0]);
            r_sy0   <= 8'(r_oy) + 8'(w_idx_nxt[IDX_W-1:COL_W]);
          end
        end
        S_DRAIN1: r_state <= S_DRAIN2;
        S_DRAIN2: begin
          r_state <= S_DONE;
          done    <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a behavioural sync-read sprite ROM.
module tb_sprite_blitter;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  spriteId;
  logic [7:0]  originX;
  logic [6:0]  originY;
  logic [11:0] romAddr;
  logic [7:0]  romData;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [7:0]  colour;
  logic        writeEn;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  int rom_mode = 0;
  int cur_ox, cur_oy, cur_id;

  int wr_count, first_c, last_c, done_count, done_c, busy_count;
  int oob_count, e3_count, even_wr, pix_err;
  logic [7:0] fx, lx, fcol, lcol;
  logic [6:0] fy, ly;

  sprite_blitter dut (
    .clk(clk), .resetn(resetn), .start(start), .spriteId(spriteId),
    .originX(originX), .originY(originY), .romAddr(romAddr), .romData(romData),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [11:0] a);
    logic [7:0] idx;
    idx = a[7:0];
    if (rom_mode == 1) return idx[0] ? (idx & 8'h7F) : 8'hE3;
    return idx;
  endfunction

  always_ff @(posedge clk) romData <= rom_val(romAddr);

  // Pulse start so it is sampled on the next rising edge, then scramble inputs.
  task automatic do_start(input int id, input int ox, input int oy);
    @(negedge clk);
    start    = 1'b1;
    spriteId = 4'(id);
    originX  = 8'(ox);
    originY  = 7'(oy);
    cur_id = id; cur_ox = ox; cur_oy = oy;
    @(posedge clk);
    #1;
    start    = 1'b0;
    spriteId = 4'hF;
    originX  = 8'h55;
    originY  = 7'h2A;
  endtask

  // Samples ncyc cycles after the accept edge; optional extra start pulses at p1/p2.
  task automatic capture(input int ncyc, input int p1, input int p2);
    int k;
    logic [11:0] a;
    wr_count = 0; first_c = -1; last_c = -1; done_count = 0; done_c = -1;
    busy_count = 0; oob_count = 0; e3_count = 0; even_wr = 0; pix_err = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (writeEn) begin
        wr_count++;
        if (first_c < 0) begin first_c = c; fx = x; fy = y; fcol = colour; end
        last_c = c; lx = x; ly = y; lcol = colour;
        k = c - 2;
        if (x > 8'd159 || y > 7'd119) oob_count++;
        if (colour == 8'hE3) e3_count++;
        if (k < 0 || k >= N) pix_err++;
        else begin
          if (k % 2 == 0) even_wr++;
          a = {4'(cur_id), 8'(k)};
          if (x !== 8'(cur_ox + k % 16) || y !== 7'(cur_oy + k / 16) || colour !== rom_val(a))
            pix_err++;
        end
      end
      if (done) begin done_count++; done_c = c; end
      if (busy) busy_count++;
      start = (c == p1 || c == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; spriteId = '0; originX = '0; originY = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({writeEn, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {writeEn, busy, done});
    end
    checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 8'd0 || romAddr !== 12'd0) begin
      errors++; $display("FAIL reset_data: x=%0d y=%0d col=%h addr=%h want all 0", x, y, colour, romAddr);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_draw;
    rom_mode = 0;
    do_start(2, 10, 20);
    capture(N + 6, -1, -1);
    checks++;
`ifdef SPRITE_TRANSPARENCY_EN
    if (wr_count !== 255) begin errors++; $display("FAIL full_wr_count: got %0d want 255", wr_count); end
`else
    if (wr_count !== 256) begin errors++; $display("FAIL full_wr_count: got %0d want 256", wr_count); end
`endif
    checks++;
    if (first_c !== 2 || fx !== 8'd10 || fy !== 7'd20 || fcol !== 8'h00) begin
      errors++; $display("FAIL full_first: cyc=%0d (%0d,%0d,%h) want cyc 2 (10,20,00)", first_c, fx, fy, fcol);
    end
    checks++;
    if (last_c !== 257 || lx !== 8'd25 || ly !== 7'd35 || lcol !== 8'hFF) begin
      errors++; $display("FAIL full_last: cyc=%0d (%0d,%0d,%h) want cyc 257 (25,35,ff)", last_c, lx, ly, lcol);
    end
    checks++;
    if (done_count !== 1 || done_c !== 258) begin
      errors++; $display("FAIL full_done: count=%0d cyc=%0d want 1 at 258", done_count, done_c);
    end
    checks++;
    if (busy_count !== 259) begin errors++; $display("FAIL full_busy: got %0d want 259", busy_count); end
    checks++;
    if (pix_err !== 0) begin errors++; $display("FAIL full_pixels: got %0d bad pixels want 0", pix_err); end
  endtask

  task automatic test_clip;
    rom_mode = 0;
    do_start(3, 152, 112);
    capture(N + 6, -1, -1);
    checks++;
    if (wr_count !== 64) begin errors++; $display("FAIL clip_wr_count: got %0d want 64", wr_count); end
    checks++;
    if (oob_count !== 0) begin errors++; $display("FAIL clip_oob: got %0d want 0", oob_count); end
    checks++;
    if (last_c !== 121 || lx !== 8'd159 || ly !== 7'd119) begin
      errors++; $display("FAIL clip_last: cyc=%0d (%0d,%0d) want cyc 121 (159,119)", last_c, lx, ly);
    end
    checks++;
    if (done_c !== 258 || pix_err !== 0) begin
      errors++; $display("FAIL clip_done: done cyc=%0d pix_err=%0d want 258/0", done_c, pix_err);
    end
  endtask

  task automatic test_start_ignored;
    rom_mode = 0;
    do_start(1, 10, 20);
    capture(N + 12, 5, 258);
    checks++;
    if (done_count !== 1 || done_c !== 258) begin
      errors++; $display("FAIL busy_start_done: count=%0d cyc=%0d want 1 at 258", done_count, done_c);
    end
    checks++;
    if (busy_count !== 259) begin errors++; $display("FAIL busy_start_busy: got %0d want 259", busy_count); end
    checks++;
    if (pix_err !== 0) begin errors++; $display("FAIL busy_start_pixels: got %0d want 0", pix_err); end
  endtask

  task automatic test_reset_mid;
    rom_mode = 0;
    do_start(2, 10, 20);
    capture(100, -1, -1);
    @(negedge clk);
    checks++;
    if (writeEn !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: we=%b busy=%b want 1 1", writeEn, busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({writeEn, busy, done} !== 3'b000 || romAddr !== 12'd0) begin
      errors++; $display("FAIL mid_abort: we/busy/done=%b addr=%h want 000/000", {writeEn, busy, done}, romAddr);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    do_start(2, 10, 20);
    capture(N + 6, -1, -1);
    checks++;
    if (first_c !== 2 || done_c !== 258 || busy_count !== 259 || pix_err !== 0) begin
      errors++; $display("FAIL mid_redraw: first=%0d done=%0d busy=%0d perr=%0d want 2/258/259/0",
                         first_c, done_c, busy_count, pix_err);
    end
  endtask

  task automatic test_transparency;
    rom_mode = 1;
    do_start(4, 20, 30);
    capture(N + 6, -1, -1);
    checks++;
`ifdef SPRITE_TRANSPARENCY_EN
    if (wr_count !== 128 || even_wr !== 0 || e3_count !== 0) begin
      errors++; $display("FAIL key_writes: wr=%0d even=%0d e3=%0d want 128/0/0", wr_count, even_wr, e3_count);
    end
`else
    if (wr_count !== 256 || even_wr !== 128 || e3_count !== 128) begin
      errors++; $display("FAIL key_writes: wr=%0d even=%0d e3=%0d want 256/128/128", wr_count, even_wr, e3_count);
    end
`endif
    checks++;
    if (done_c !== 258 || pix_err !== 0) begin
      errors++; $display("FAIL key_timing: done=%0d perr=%0d want 258/0", done_c, pix_err);
    end
  endtask

  task automatic test_back_to_back;
    rom_mode = 0;
    do_start(1, 10, 20);
    capture(N + 3, -1, -1);
    checks++;
    if (done_c !== 258) begin errors++; $display("FAIL b2b_first_done: got %0d want 258", done_c); end
    do_start(5, 40, 50);
    capture(N + 6, -1, -1);
    checks++;
    if (first_c !== 2 || fx !== 8'd40 || fy !== 7'd50) begin
      errors++; $display("FAIL b2b_first_pix: cyc=%0d (%0d,%0d) want 2 (40,50)", first_c, fx, fy);
    end
    checks++;
    if (done_c !== 258 || busy_count !== 259 || pix_err !== 0) begin
      errors++; $display("FAIL b2b_second: done=%0d busy=%0d perr=%0d want 258/259/0", done_c, busy_count, pix_err);
    end
  endtask

  initial begin
    test_reset;
    test_full_draw;
    test_clip;
    test_start_ignored;
    test_reset_mid;
    test_transparency;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
